pc_trap_unit: RTL and testbench

Parametrised program-counter unit for the single-cycle/pipelined RISC-V core, successor to the basic PC register. It adds a stall hold, configurable reset and trap vectors, and a trap state machine. The trap machine saves the return PC, supports a trap-return, latches pending triggers and counts traps taken. It sits between next-PC selection logic and instruction memory.

---
 rtl/pc_pkg.sv | 12 +
 rtl/pc_trap_ctrl.sv | 78 +++++++
 rtl/pc_trap_unit.sv | 56 +++++
 tb/tb_pc_trap_unit.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and default vectors for the PC/trap unit
package pc_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        TRAP = 1'b1
    } pc_state_t;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_000C;

endpackage

// File: rtl/pc_trap_ctrl.sv
// rtl/pc_trap_ctrl.sv - trap FSM, pending-trigger latch and saturating trap counter
module pc_trap_ctrl
    import pc_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             trg,
    input  logic             trap_ret,
    output logic             take_trap,
    output logic             do_return,
    output logic             in_trap,
    output logic             pending,
    output logic [CNT_W-1:0] trap_cnt
);

    pc_state_t state;
    pc_state_t state_next;
    logic      adv;
    logic      req;
    logic      pending_next;

    assign adv     = !stall;
    assign req     = trg | pending;
    assign in_trap = (state == TRAP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Any trigger not consumed by a trap this cycle is remembered, so
    // triggers arriving while stalled or already trapped are never lost.
    always_comb begin
        state_next   = state;
        take_trap    = 1'b0;
        do_return    = 1'b0;
        pending_next = pending | trg;
        case (state)
            RUN: begin
                if (adv && req) begin
                    take_trap    = 1'b1;
                    state_next   = TRAP;
                    pending_next = 1'b0;
                end
            end
            TRAP: begin
                if (adv && trap_ret) begin
                    do_return  = 1'b1;
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
        end else begin
            pending <= pending_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trap_cnt <= '0;
        end else if (take_trap && (trap_cnt != {CNT_W{1'b1}})) begin
            trap_cnt <= trap_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pc_trap_unit.sv
// rtl/pc_trap_unit.sv - program counter with stall hold, trap entry/return and saved EPC
module pc_trap_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
    parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(DEFAULT_TRAP_VECTOR),
    parameter int               CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_i,
    input  logic [WIDTH-1:0] PC_Next_i,
    input  logic             trg_i,
    input  logic             trap_ret_i,
    output logic [WIDTH-1:0] PC_o,
    output logic [WIDTH-1:0] EPC_o,
    output logic             in_trap_o,
    output logic             trg_pending_o,
    output logic [CNT_W-1:0] trap_cnt_o
);

    logic take_trap;
    logic do_return;

    pc_trap_ctrl #(
        .CNT_W(CNT_W)
    ) u_ctrl (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall_i),
        .trg      (trg_i),
        .trap_ret (trap_ret_i),
        .take_trap(take_trap),
        .do_return(do_return),
        .in_trap  (in_trap_o),
        .pending  (trg_pending_o),
        .trap_cnt (trap_cnt_o)
    );

    // The return address is the PC that would have executed had the trap not hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PC_o  <= RESET_VECTOR;
            EPC_o <= '0;
        end else if (take_trap) begin
            PC_o  <= TRAP_VECTOR;
            EPC_o <= PC_Next_i;
        end else if (do_return) begin
            PC_o <= EPC_o;
        end else if (!stall_i) begin
            PC_o <= PC_Next_i;
        end
    end

endmodule

// File: tb/tb_pc_trap_unit.sv
// tb/tb_pc_trap_unit.sv - directed and randomized checks of pc_trap_unit against a behavioural model
module tb_pc_trap_unit;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_000C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic [31:0] PC_Next_i = '0;
    logic        trg_i = 1'b0;
    logic        trap_ret_i = 1'b0;

    logic [31:0] pc_a, epc_a, pc_b, epc_b;
    logic        in_trap_a, pend_a, in_trap_b, pend_b;
    logic [7:0]  cnt_a;
    logic [1:0]  cnt_b;

    int tests = 0;
    int fails = 0;

    logic [31:0] m_pc, m_epc;
    bit          m_trap, m_pend;
    int          m_cnt8, m_cnt2;

    always #5 clk = ~clk;

    pc_trap_unit dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .PC_Next_i(PC_Next_i),
        .trg_i(trg_i), .trap_ret_i(trap_ret_i), .PC_o(pc_a), .EPC_o(epc_a),
        .in_trap_o(in_trap_a), .trg_pending_o(pend_a), .trap_cnt_o(cnt_a)
    );

    pc_trap_unit #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .stall_i(stall_i), .PC_Next_i(PC_Next_i),
        .trg_i(trg_i), .trap_ret_i(trap_ret_i), .PC_o(pc_b), .EPC_o(epc_b),
        .in_trap_o(in_trap_b), .trg_pending_o(pend_b), .trap_cnt_o(cnt_b)
    );

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = RV; m_epc = '0; m_trap = 0; m_pend = 0; m_cnt8 = 0; m_cnt2 = 0;
    endtask

    task automatic model_clock();
        bit adv, req;
        adv = !stall_i;
        req = trg_i || m_pend;
        if (!m_trap) begin
            if (adv && req) begin
                m_epc  = PC_Next_i;
                m_pc   = TV;
                m_trap = 1;
                m_pend = 0;
                m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
                m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
            end else begin
                if (adv) m_pc = PC_Next_i;
                if (trg_i) m_pend = 1;
            end
        end else begin
            if (adv && trap_ret_i) begin
                m_pc   = m_epc;
                m_trap = 0;
            end else if (adv) begin
                m_pc = PC_Next_i;
            end
            if (trg_i) m_pend = 1;
        end
    endtask

    task automatic check_all(input string tag);
        cmp({tag, ".pc"},      pc_a, m_pc);
        cmp({tag, ".epc"},     epc_a, m_epc);
        cmp({tag, ".in_trap"}, {31'd0, in_trap_a}, {31'd0, m_trap});
        cmp({tag, ".pending"}, {31'd0, pend_a}, {31'd0, m_pend});
        cmp({tag, ".cnt"},     {24'd0, cnt_a}, m_cnt8);
        cmp({tag, ".pc2"},     pc_b, m_pc);
        cmp({tag, ".cnt2"},    {30'd0, cnt_b}, m_cnt2);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_clock();
        #1;
        check_all(tag);
    endtask

    task automatic drive(input bit s, input logic [31:0] nx, input bit t, input bit r);
        stall_i = s; PC_Next_i = nx; trg_i = t; trap_ret_i = r;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        // sequential advance, then stall hold
        drive(0, 32'h4, 0, 0);  step("seq4");
        drive(0, 32'h8, 0, 0);  step("seq8");
        drive(0, 32'h10, 0, 0); step("seq10");
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h20, 0, 0); step("stall");
            cmp("stall_hold", pc_a, 32'h10);
        end

        // trap entry and return
        drive(0, 32'h24, 1, 0); step("trap");
        cmp("trap_pc", pc_a, 32'hC);
        cmp("trap_epc", epc_a, 32'h24);
        cmp("trap_cnt", {24'd0, cnt_a}, 32'd1);
        drive(0, 32'h50, 0, 0); step("in_trap");
        drive(0, 32'h54, 0, 1); step("ret");
        cmp("ret_pc", pc_a, 32'h24);

        // trigger during stall is held pending
        drive(1, 32'h28, 1, 0); step("stall_trg");
        cmp("stall_pend", {31'd0, pend_a}, 32'd1);
        drive(0, 32'h60, 0, 0); step("pend_take");
        cmp("pend_pc", pc_a, 32'hC);
        cmp("pend_cnt", {24'd0, cnt_a}, 32'd2);

        // return and trigger in the same cycle
        drive(0, 32'h64, 1, 1); step("ret_trg");
        cmp("ret_trg_pc", pc_a, 32'h60);
        cmp("ret_trg_pend", {31'd0, pend_a}, 32'd1);
        drive(0, 32'h70, 0, 0); step("retrap");
        cmp("retrap_pc", pc_a, 32'hC);
        cmp("retrap_epc", epc_a, 32'h70);

        // async reset while in TRAP at PC=0x40
        drive(0, 32'h40, 0, 0); step("pc40");
        cmp("pc40_val", pc_a, 32'h40);
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        #1 rst = 1'b0;
        drive(0, 32'h0, 0, 0);
        step("post_rst");

        // counter saturation on the narrow instance
        for (int i = 0; i < 5; i++) begin
            drive(0, 32'h100 + 32'(i * 8), 1, 0); step("sat_trap");
            cmp("sat_cnt2", {30'd0, cnt_b}, (i < 3) ? i + 1 : 3);
            drive(0, 32'h200, 0, 1); step("sat_ret");
        end

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(3) == 0, {$urandom_range(32'h3FFF), 2'b00},
                  $urandom_range(4) == 0, $urandom_range(3) == 0);
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
